// File: rtl/cnn_ahb_pkg.sv
// cnn_ahb_pkg: bus encodings, CNN slave register offsets, ctrl bit positions
// and loader state encoding shared by the loader and its transfer engine.
package cnn_ahb_pkg;

   localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

   localparam logic [15:0] OFS_CTRL = 16'h1000;
   localparam logic [15:0] OFS_OUT1 = 16'h1004;
   localparam logic [15:0] OFS_L1_W = 16'h2000;
   localparam logic [15:0] OFS_V_B  = 16'h9000;

   localparam int CTRL_RESET_BIT = 0;
   localparam int CTRL_FIN_BIT   = 1;
   localparam int CTRL_EN_BIT    = 2;

   // ctrl values: hold the CNN in reset, or release it with enable set
   localparam logic [31:0] CTRL_HOLD_RESET = 32'h1 << CTRL_RESET_BIT;
   localparam logic [31:0] CTRL_RUN        = 32'h1 << CTRL_EN_BIT;

   localparam int NUM_OUTS = 6;

   typedef enum logic [3:0] {
      ST_IDLE, ST_RST_A, ST_RST_D, ST_WAIT_CMD, ST_LOAD_A, ST_LOAD_D,
      ST_RUN_A, ST_RUN_D, ST_POLL_A, ST_POLL_D, ST_RD_A, ST_RD_D, ST_DONE
   } state_e;

endpackage

// File: rtl/cnn_ahb_xfer.sv
// cnn_ahb_xfer: single non-pipelined AHB-Lite transfer. A request loads the
// address phase; once HREADY takes it the data phase follows, and done_o
// marks the HREADY cycle that completes it.
module cnn_ahb_xfer
   import cnn_ahb_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        write_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        hready_i,
   input  logic [31:0] hrdata_i,
   output logic [31:0] haddr_o,
   output logic [1:0]  htrans_o,
   output logic        hwrite_o,
   output logic [31:0] hwdata_o,
   output logic        done_o,
   output logic [31:0] rdata_o
);

   logic [1:0]  htrans_q;
   logic [31:0] haddr_q, hwdata_q, wdata_q;
   logic        hwrite_q, dph_q;

   // address phase on request, data phase once HREADY accepts the address
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         htrans_q <= HTRANS_IDLE;
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         hwdata_q <= '0;
         wdata_q  <= '0;
         dph_q    <= 1'b0;
      end else begin
         if (dph_q && hready_i) dph_q <= 1'b0;
         if (req_i) begin
            htrans_q <= HTRANS_NONSEQ;
            haddr_q  <= addr_i;
            hwrite_q <= write_i;
            wdata_q  <= wdata_i;
         end else if (htrans_q == HTRANS_NONSEQ && hready_i) begin
            htrans_q <= HTRANS_IDLE;
            dph_q    <= 1'b1;
            if (hwrite_q) hwdata_q <= wdata_q;
         end
      end
   end

   assign haddr_o  = haddr_q;
   assign htrans_o = htrans_q;
   assign hwrite_o = hwrite_q;
   assign hwdata_o = hwdata_q;
   assign done_o   = dph_q & hready_i;
   assign rdata_o  = hrdata_i;

endmodule

// File: rtl/cnn_ahb_loader.sv
// cnn_ahb_loader: loads CNN weights/biases over AHB-Lite, runs the network,
// polls for completion and reads back the six class outputs.
// Optional macro CNN_LOADER_TIMEOUT_EN bounds polling to POLL_LIMIT reads,
// after which the CNN is put back into reset and ERR is raised.
module cnn_ahb_loader
   import cnn_ahb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
   parameter int unsigned POLL_LIMIT = 65535
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [15:0] CMD_ADDR,
   input  logic [31:0] CMD_DATA,
   input  logic        CMD_LAST,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   output logic        BUSY,
   output logic        RES_VALID,
   output logic [95:0] RES_DATA,
   output logic        ERR
);

   if (BASE_ADDR[15:0] != 16'h0 || POLL_LIMIT == 0 || POLL_LIMIT > 65535) begin : g_cfg_check
      $error("cnn_ahb_loader: BASE_ADDR must be 64KB aligned and POLL_LIMIT in 1..65535");
   end

   localparam logic [31:0] CTRL_ADDR = BASE_ADDR | {16'h0, OFS_CTRL};

   state_e      state_q, state_d;
   logic        last_q, last_d;
   logic [2:0]  idx_q, idx_d;
   logic [95:0] res_q, res_d;
   logic        abort_q;
   logic        req, req_write, xfer_done;
   logic [31:0] req_addr, req_wdata, rdata;
`ifdef CNN_LOADER_TIMEOUT_EN
   logic        abort_d, err_q, err_d;
   logic [15:0] cnt_q, cnt_d;
`endif

   cnn_ahb_xfer u_xfer (
      .clk_i    (HCLK),
      .rst_ni   (HRESETn),
      .req_i    (req),
      .write_i  (req_write),
      .addr_i   (req_addr),
      .wdata_i  (req_wdata),
      .hready_i (HREADY),
      .hrdata_i (HRDATA),
      .haddr_o  (HADDR),
      .htrans_o (HTRANS),
      .hwrite_o (HWRITE),
      .hwdata_o (HWDATA),
      .done_o   (xfer_done),
      .rdata_o  (rdata)
   );

   // sequencing: each bus access is issued on entry to its *_A state
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      idx_d     = idx_q;
      res_d     = res_q;
      req       = 1'b0;
      req_write = 1'b1;
      req_addr  = CTRL_ADDR;
      req_wdata = CTRL_HOLD_RESET;
`ifdef CNN_LOADER_TIMEOUT_EN
      abort_d   = abort_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
`endif
      case (state_q)
         ST_IDLE: if (CMD_VALID) begin
            state_d = ST_RST_A;
            req     = 1'b1;
         end
         ST_RST_A:  if (HREADY) state_d = ST_RST_D;
         ST_RST_D: if (xfer_done) begin
            state_d = abort_q ? ST_IDLE : ST_WAIT_CMD;
`ifdef CNN_LOADER_TIMEOUT_EN
            abort_d = 1'b0;
`endif
         end
         ST_WAIT_CMD: if (CMD_VALID) begin
            state_d   = ST_LOAD_A;
            req       = 1'b1;
            req_addr  = BASE_ADDR | {16'h0, CMD_ADDR[15:2], 2'b00};
            req_wdata = CMD_DATA;
            last_d    = CMD_LAST;
`ifdef CNN_LOADER_TIMEOUT_EN
            err_d     = 1'b0;
`endif
         end
         ST_LOAD_A: if (HREADY) state_d = ST_LOAD_D;
         ST_LOAD_D: if (xfer_done) begin
            if (last_q) begin
               state_d   = ST_RUN_A;
               req       = 1'b1;
               req_wdata = CTRL_RUN;
            end else begin
               state_d = ST_WAIT_CMD;
            end
         end
         ST_RUN_A: if (HREADY) state_d = ST_RUN_D;
         ST_RUN_D: if (xfer_done) begin
            state_d   = ST_POLL_A;
            req       = 1'b1;
            req_write = 1'b0;
`ifdef CNN_LOADER_TIMEOUT_EN
            cnt_d     = '0;
`endif
         end
         ST_POLL_A: if (HREADY) state_d = ST_POLL_D;
         ST_POLL_D: if (xfer_done) begin
            if (rdata[CTRL_FIN_BIT]) begin
               state_d   = ST_RD_A;
               req       = 1'b1;
               req_write = 1'b0;
               req_addr  = BASE_ADDR | {16'h0, OFS_OUT1};
               idx_d     = '0;
            end
`ifdef CNN_LOADER_TIMEOUT_EN
            // give up: put the CNN back into reset, then return to IDLE
            else if (({16'h0, cnt_q} + 32'd1) == POLL_LIMIT) begin
               state_d = ST_RST_A;
               req     = 1'b1;
               abort_d = 1'b1;
               err_d   = 1'b1;
            end
`endif
            else begin
               state_d   = ST_POLL_A;
               req       = 1'b1;
               req_write = 1'b0;
`ifdef CNN_LOADER_TIMEOUT_EN
               cnt_d     = cnt_q + 16'd1;
`endif
            end
         end
         ST_RD_A: if (HREADY) state_d = ST_RD_D;
         ST_RD_D: if (xfer_done) begin
            res_d[{idx_q, 4'h0} +: 16] = rdata[15:0];
            if (idx_q == 3'(NUM_OUTS - 1)) begin
               state_d = ST_DONE;
            end else begin
               idx_d     = idx_q + 3'd1;
               state_d   = ST_RD_A;
               req       = 1'b1;
               req_write = 1'b0;
               req_addr  = BASE_ADDR | {16'h0, OFS_OUT1 + {11'h0, idx_d, 2'b00}};
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // state, latched LAST flag, output index and result capture
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b0;
         idx_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
      end
   end

`ifdef CNN_LOADER_TIMEOUT_EN
   // poll counter, abort path and sticky error
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         abort_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         abort_q <= abort_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
   assign ERR = err_q;
`else
   assign abort_q = 1'b0;
   assign ERR     = 1'b0;
`endif

   assign CMD_READY = (state_q == ST_WAIT_CMD);
   assign BUSY      = (state_q != ST_IDLE);
   assign RES_VALID = (state_q == ST_DONE);
   assign RES_DATA  = res_q;
   assign HSIZE     = 3'b010;

   // slave only honours 16-bit data; command byte lanes are word aligned
   logic unused_bits;
   assign unused_bits = ^{rdata[31:16], CMD_ADDR[1:0]};

endmodule

// File: tb/tb_cnn_ahb_loader.sv
// tb_cnn_ahb_loader: directed and randomized runs against a behavioural
// AHB slave and an expected-transfer list built from the command stream.
module tb_cnn_ahb_loader;

   localparam logic [31:0] BASE  = 32'h4000_0000;
   localparam logic [31:0] CTRL  = BASE + 32'h1000;
   localparam int          LIMIT = 8;

   logic        HCLK = 1'b0, HRESETn = 1'b0, CMD_VALID = 1'b0, CMD_LAST = 1'b0, HREADY = 1'b1;
   logic [15:0] CMD_ADDR = '0;
   logic [31:0] CMD_DATA = '0, HRDATA = '0;
   logic        CMD_READY, HWRITE, BUSY, RES_VALID, ERR;
   logic [31:0] HADDR, HWDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [95:0] RES_DATA;

   cnn_ahb_loader #(.BASE_ADDR(BASE), .POLL_LIMIT(LIMIT)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_LAST(CMD_LAST), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADY(HREADY), .BUSY(BUSY), .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .ERR(ERR)
   );

   initial forever #5 HCLK = ~HCLK;

   typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } xfer_t;
   xfer_t expq[$];

   int npass = 0, ntot = 0, nfail = 0;
   bit          pend = 0, wait_rand = 0;
   logic [31:0] p_addr = '0;
   logic        p_write = 1'b0;
   int          stall_cnt = 0, stall_param = 0, polls_left = 0, rv_count = 0;
   logic [31:0] outv [6];
   logic [15:0] cmd_a [8];
   logic [31:0] cmd_d [8];

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void push(input logic [31:0] a, input logic w, input logic [31:0] d);
      xfer_t e;
      e.addr = a; e.wr = w; e.data = d;
      expq.push_back(e);
   endfunction

   function automatic logic [31:0] slave_read(input logic [31:0] a);
      if (a == CTRL)
         return ($urandom & ~32'h2) | ((polls_left == 0) ? 32'h2 : 32'h0);
      else if (a >= BASE + 32'h1004 && a <= BASE + 32'h1018)
         return outv[(a - BASE - 32'h1004) >> 2];
      else
         return $urandom;
   endfunction

   task automatic data_phase();
      xfer_t e;
      chk("dph_htrans", HTRANS, 2'b00);
      chk("dph_haddr", HADDR, p_addr);
      chk("dph_expected", expq.size() != 0, 1'b1);
      HRDATA = slave_read(p_addr);
      if (expq.size() != 0) begin
         e = expq[0];
         if (p_write && e.wr) chk("dph_hwdata", HWDATA, e.data);
         if (HREADY) begin
            chk("xfer_addr", p_addr, e.addr);
            chk("xfer_write", p_write, e.wr);
            void'(expq.pop_front());
         end
      end
      if (HREADY) begin
         if (!p_write && p_addr == CTRL && polls_left > 0) polls_left--;
         pend = 0;
         stall_cnt = 0;
      end
   endtask

   // AHB slave: inputs for the current cycle are chosen mid-cycle
   initial begin
      forever begin
         @(negedge HCLK);
         if (!HRESETn) begin
            pend = 0; stall_cnt = 0; HREADY = 1'b1;
         end else begin
            if (RES_VALID) rv_count++;
            if (pend && p_write && p_addr != CTRL && stall_cnt < stall_param) begin
               HREADY = 1'b0; stall_cnt++;
            end else if (wait_rand && $urandom_range(0, 3) == 0) HREADY = 1'b0;
            else HREADY = 1'b1;
            if (pend) data_phase();
            else if (HTRANS == 2'b10) begin
               chk("hsize", HSIZE, 3'b010);
               if (HREADY) begin pend = 1; p_addr = HADDR; p_write = HWRITE; end
            end
         end
      end
   end

   task automatic send_cmd(input logic [15:0] a, input logic [31:0] d, input logic last);
      int n = 0;
      CMD_VALID = 1'b1; CMD_ADDR = a; CMD_DATA = d; CMD_LAST = last;
      while (!CMD_READY && n < 500) begin @(negedge HCLK); n++; end
      chk("cmd_ready", CMD_READY, 1'b1);
      @(negedge HCLK);
      CMD_VALID = 1'b0; CMD_LAST = 1'b0;
      chk("err_cleared", ERR, 1'b0);
   endtask

   task automatic do_run(input int n, input int polls, input bit to);
      logic [95:0] exp_res, prev_res;
      int w = 0;
      @(negedge HCLK);
      prev_res = RES_DATA;
      rv_count = 0; polls_left = polls;
      push(CTRL, 1'b1, 32'h1);
      for (int i = 0; i < n; i++) push(BASE + 32'(cmd_a[i]) - 32'(cmd_a[i] % 4), 1'b1, cmd_d[i]);
      push(CTRL, 1'b1, 32'h4);
      if (!to) begin
         for (int i = 0; i <= polls; i++) push(CTRL, 1'b0, 32'h0);
         for (int k = 0; k < 6; k++) push(BASE + 32'h1004 + 32'(4 * k), 1'b0, 32'h0);
      end else begin
         for (int i = 0; i < LIMIT; i++) push(CTRL, 1'b0, 32'h0);
         push(CTRL, 1'b1, 32'h1);
      end
      for (int i = 0; i < n; i++) send_cmd(cmd_a[i], cmd_d[i], i == n - 1);
      while (BUSY && w < 3000) begin @(negedge HCLK); w++; end
      chk("run_finished", BUSY, 1'b0);
      @(negedge HCLK);
      exp_res = '0;
      for (int k = 0; k < 6; k++) exp_res[16 * k +: 16] = outv[k][15:0];
      chk("res_valid_pulses", rv_count, to ? 0 : 1);
      chk("res_data", RES_DATA, to ? prev_res : exp_res);
      chk("xfers_left", expq.size(), 0);
      chk("err", ERR, to);
   endtask

   initial begin
      int w;
      repeat (3) @(negedge HCLK);
      chk("rst_htrans", HTRANS, 2'b00);
      chk("rst_hwrite", HWRITE, 1'b0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_cmd_ready", CMD_READY, 1'b0);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_res_valid", RES_VALID, 1'b0);
      chk("rst_res_data", RES_DATA, 96'h0);
      chk("rst_err", ERR, 1'b0);
      HRESETn = 1'b1;

      // directed load and run, zero wait states
      cmd_a[0] = 16'h2000; cmd_d[0] = 32'h11;
      cmd_a[1] = 16'h2004; cmd_d[1] = 32'h22;
      cmd_a[2] = 16'h3000; cmd_d[2] = 32'h33;
      outv[0] = 32'hDEAD_FFF0; outv[1] = 32'h1234_0001; outv[2] = 32'h0000_0002;
      outv[3] = 32'hFFFF_0003; outv[4] = 32'h8000_0004; outv[5] = 32'h0001_0005;
      do_run(3, 4, 1'b0);
      chk("res_directed", RES_DATA, 96'h0005_0004_0003_0002_0001_FFF0);

      // unaligned command address, data phase stalled 3 cycles per word
      stall_param = 3;
      cmd_a[0] = 16'h2003; cmd_d[0] = 32'hCAFE_0123;
      cmd_a[1] = 16'h9FFC; cmd_d[1] = 32'h0000_BEEF;
      for (int k = 0; k < 6; k++) outv[k] = $urandom;
      do_run(2, 0, 1'b0);
      stall_param = 0;

`ifdef CNN_LOADER_TIMEOUT_EN
      cmd_a[0] = 16'h4000; cmd_d[0] = 32'h77;
      do_run(1, 1000, 1'b1);
`endif

      // randomized runs with random wait states
      wait_rand = 1;
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            cmd_a[i] = 16'($urandom_range(16'h2000, 16'h9FFF));
            cmd_d[i] = $urandom;
         end
         for (int k = 0; k < 6; k++) outv[k] = $urandom;
         do_run(n, $urandom_range(0, 5), 1'b0);
      end
      wait_rand = 0;

      // reset asserted while a parameter write data phase is stalled
      stall_param = 50;
      @(negedge HCLK);
      push(CTRL, 1'b1, 32'h1);
      push(BASE + 32'h5000, 1'b1, 32'h5555);
      send_cmd(16'h5000, 32'h5555, 1'b0);
      w = 0;
      while (!(pend && stall_cnt >= 2) && w < 200) begin @(negedge HCLK); w++; end
      chk("stall_reached", pend && stall_cnt >= 2, 1'b1);
      #2 HRESETn = 1'b0;
      #1;
      chk("arst_htrans", HTRANS, 2'b00);
      chk("arst_busy", BUSY, 1'b0);
      chk("arst_cmd_ready", CMD_READY, 1'b0);
      chk("arst_res_data", RES_DATA, 96'h0);
      expq.delete();
      stall_param = 0;
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;

      // recovery run after the abort
      cmd_a[0] = 16'h6008; cmd_d[0] = 32'h0BAD_F00D;
      for (int k = 0; k < 6; k++) outv[k] = $urandom;
      do_run(1, 2, 1'b0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/cnn_ahb_loader.md
# cnn_ahb_loader

AHB-Lite initiator that drives the CNN accelerator's slave register map on the system bus. It accepts a stream of weight/bias write commands and writes each into the accelerator's parameter memories. It then starts the CNN, polls the finished flag and reads back the six class outputs. It sits between a configuration source (boot ROM reader or debug bridge) and the CNN slave, and replaces CPU-driven parameter loading.

## Interface
Parameters:
- BASE_ADDR, 32'h4000_0000, base of the CNN slave window; bits [15:0] must be zero
- POLL_LIMIT, 65535, maximum finished-flag polls before error (timeout build only)

Ports:
- HCLK  in  1  bus clock; the only clock
- HRESETn  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command word valid
- CMD_READY  out  1  loader accepts command this cycle
- CMD_ADDR  in  16  byte offset in slave window (0x2000–0x9FFC parameter regions)
- CMD_DATA  in  32  write data; slave uses bits [15:0]
- CMD_LAST  in  1  final parameter word; triggers the run sequence
- HADDR  out  32  AHB address
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only
- HWRITE  out  1  transfer direction
- HSIZE  out  3  constant 3'b010 (word)
- HWDATA  out  32  write data, driven in the data phase
- HRDATA  in  32  read data
- HREADY  in  1  transfer-complete / bus ready
- BUSY  out  1  state ≠ IDLE
- RES_VALID  out  1  one-cycle pulse, results valid
- RES_DATA  out  96  {OUT6..OUT1}, HRDATA[15:0] of each output read
- ERR  out  1  sticky poll timeout; cleared on next accepted command

## Operation
- Reset values: HTRANS=0, HWRITE=0, HADDR=0, HWDATA=0, CMD_READY=0, BUSY=0, RES_VALID=0, RES_DATA=0, ERR=0; state IDLE.
- States: IDLE, RST_A, RST_D, WAIT_CMD, LOAD_A, LOAD_D, RUN_A, RUN_D, POLL_A, POLL_D, RD_A, RD_D, DONE.
- IDLE: on CMD_VALID, go to RST_A; the first command is not consumed here.
- RST_A/RST_D: write 32'h1 to BASE+0x1000 (ctrl: CNN held in reset, disabled).
- WAIT_CMD: CMD_READY=1; on VALID&READY latch addr (bits [1:0] forced 0), data and last; go to LOAD_A.
- LOAD_A/LOAD_D: write latched word to BASE|addr. Then go to RUN_A if last, else WAIT_CMD.
- RUN_A/RUN_D: write 32'h4 to ctrl (enable=1, reset=0).
- POLL_A/POLL_D: read ctrl. If HRDATA[1]=1, go to RD_A with index 0. Otherwise repeat POLL_A.
- RD_A/RD_D: read BASE+0x1004+4·index and store HRDATA[15:0] into slice index. Index 0..5; after 5, go to DONE.
- DONE: RES_VALID=1 for one cycle, then IDLE. RES_DATA holds until the next DONE.
- Each *_A state drives HTRANS=NONSEQ, HADDR and HWRITE. Each *_D state drives HTRANS=IDLE, and HWDATA for writes.

## Timing
- An address phase advances only when HREADY=1. A data phase completes, and HRDATA is sampled, only when HREADY=1; otherwise all outputs hold.
- No back-to-back pipelining: every transfer is A then D (2 cycles with zero wait states).
- Per parameter word: 3 cycles (WAIT_CMD, LOAD_A, LOAD_D).
- From the DONE-causing poll data phase to RES_VALID: 12 cycles (6 reads) with zero wait states.
- CMD_VALID asserted outside WAIT_CMD is ignored and held off by the source.
- Asynchronous reset mid-transfer: immediate return to IDLE and HTRANS=IDLE. The slave sees the transfer aborted.
- A new command arriving in DONE is accepted only after the return to IDLE.

## Configuration
- CNN_LOADER_TIMEOUT_EN defined: a 16-bit poll counter increments per POLL_D. When it reaches POLL_LIMIT, the loader writes 32'h1 to ctrl, sets ERR and returns to IDLE without pulsing RES_VALID.
- CNN_LOADER_TIMEOUT_EN undefined: polling is unbounded, ERR is tied to 0 and POLL_LIMIT is unused.

## Structure
- Shared package cnn_ahb_pkg holds:
  - HTRANS encodings (IDLE, NONSEQ)
  - slave offsets: CTRL 0x1000, OUT1 0x1004, L1_W 0x2000 … V_B 0x9000
  - ctrl bit positions: reset 0, finished 1, enable 2
  - the state enum
- One sub-module, cnn_ahb_xfer, implements a single-transfer engine: address phase, data phase, HREADY wait. The FSM issues requests to it.

## Test plan
- Reset mid-LOAD_D with HREADY=0 -> next cycle HTRANS=0, BUSY=0, CMD_READY=0.
- Three commands (0x2000/0x11, 0x2004/0x22, 0x3000/0x33 LAST), HREADY=1 -> writes in order: ctrl←1, 0x4000_2000←0x11, 0x4000_2004←0x22, 0x4000_3000←0x33, ctrl←4. Each HWDATA appears one cycle after its address.
- Slave holds ctrl bit1=0 for 4 polls, then 1; outputs 0xFFF0,1,2,3,4,5 -> RES_VALID once, RES_DATA=96'h0005_0004_0003_0002_0001_FFF0.
- HREADY low for 3 cycles in a write data phase -> HADDR/HWDATA stable, no extra transfer issued.
- CMD_ADDR=0x2003 -> HADDR=0x4000_2000.
- CNN_LOADER_TIMEOUT_EN with POLL_LIMIT=8 and finished never set -> 8 polls, then ctrl←1, ERR=1, no RES_VALID. The next accepted command clears ERR.
